// File: rtl/sound_ram_arbiter.sv
// sound_ram_arbiter: serialises DOC and host accesses to the sound RAM through a
// fixed 4-cycle transaction, DOC first, with a bounded wait for the host.
module sound_ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int HOST_MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              doc_req,
    input  logic [ADDR_W-1:0] doc_addr,
    output logic              doc_ack,
    output logic [DATA_W-1:0] doc_rdata,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, ACK = 2'd3;
    localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

    logic [1:0] state;
    logic       owner_host;
    logic       owner_wr;
    logic [3:0] wait_cnt;
    logic       doc_win;

    // DOC loses priority once the host has watched MAX_WAIT DOC grants go by
    always_comb doc_win = doc_req && (wait_cnt < MAX_WAIT);
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_host <= 1'b0;
            owner_wr   <= 1'b0;
            wait_cnt   <= 4'd0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            doc_ack    <= 1'b0;
            host_ack   <= 1'b0;
            doc_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            doc_ack  <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (doc_win) begin
                        state      <= ISSUE;
                        owner_host <= 1'b0;
                        owner_wr   <= 1'b0;
                        ram_addr   <= doc_addr;
                        ram_we     <= 1'b0;
                        if (host_req) wait_cnt <= wait_cnt + 4'd1;
                    end else if (host_req) begin
                        state      <= ISSUE;
                        owner_host <= 1'b1;
                        owner_wr   <= host_wr;
                        ram_addr   <= host_addr;
                        ram_we     <= host_wr;
                        ram_wdata  <= host_wdata;
                        wait_cnt   <= 4'd0;
                    end
                end
                ISSUE: begin
                    ram_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (owner_host) begin
                        host_ack <= 1'b1;
                        if (!owner_wr) host_rdata <= ram_rdata;
                    end else begin
                        doc_ack   <= 1'b1;
                        doc_rdata <= ram_rdata;
                    end
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
